// File: rtl/systolic_2x2.sv
// 2x2 output-stationary-free systolic grid for pairwise 1-D gravity terms.
// i-bodies flow left-to-right along rows, j-bodies flow top-to-bottom along columns.

module systolic_n_body_2x2_cell #(
    parameter real G = 1.0
) (
    input  logic clk,
    input  logic rst_n,
    input  real  in_q_i,
    input  real  in_m_i,
    input  real  in_q_j,
    input  real  in_m_j,
    input  real  in_p_right,
    input  real  in_p_down,
    output real  out_q_i,
    output real  out_m_i,
    output real  out_q_j,
    output real  out_m_j,
    output real  out_p_right,
    output real  out_p_down
);

    real d;
    real inv;
    real a_i;
    real a_j;

    // Self-pairs and zero-mass bubbles contribute nothing and never reach the divider.
    always_comb begin
        d   = in_q_j - in_q_i;
        inv = 0.0;
        a_i = 0.0;
        a_j = 0.0;
        if (d != 0.0 && in_m_i != 0.0 && in_m_j != 0.0) begin
            inv = ((d > 0.0) ? 1.0 : -1.0) / (d * d);
            a_i = G * in_m_j * inv;
            a_j = -G * in_m_i * inv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_i     <= 0.0;
            out_m_i     <= 0.0;
            out_q_j     <= 0.0;
            out_m_j     <= 0.0;
            out_p_right <= 0.0;
            out_p_down  <= 0.0;
        end else begin
            out_q_i     <= in_q_i;
            out_m_i     <= in_m_i;
            out_q_j     <= in_q_j;
            out_m_j     <= in_m_j;
            out_p_right <= in_p_right + a_i;
            out_p_down  <= in_p_down + a_j;
        end
    end

endmodule

module systolic_2x2 #(
    parameter real G = 1.0
) (
    input  logic clk,
    input  logic rst_n,
    input  real  q_0i,
    input  real  q_1i,
    input  real  q_0j,
    input  real  q_1j,
    input  real  m_0i,
    input  real  m_1i,
    input  real  m_0j,
    input  real  m_1j,
    input  real  pr_0,
    input  real  pr_1,
    input  real  pd_0,
    input  real  pd_1,
    output real  out_pr_0,
    output real  out_pr_1,
    output real  out_pd_0,
    output real  out_pd_1
);

    // Row links indexed [row][stage], column links indexed [stage][col];
    // stage 0 is the grid edge, stage 2 leaves the grid.
    real q_i_w [2][3];
    real m_i_w [2][3];
    real p_r_w [2][3];
    real q_j_w [3][2];
    real m_j_w [3][2];
    real p_d_w [3][2];

    assign q_i_w[0][0] = q_0i;
    assign q_i_w[1][0] = q_1i;
    assign m_i_w[0][0] = m_0i;
    assign m_i_w[1][0] = m_1i;
    assign p_r_w[0][0] = pr_0;
    assign p_r_w[1][0] = pr_1;
    assign q_j_w[0][0] = q_0j;
    assign q_j_w[0][1] = q_1j;
    assign m_j_w[0][0] = m_0j;
    assign m_j_w[0][1] = m_1j;
    assign p_d_w[0][0] = pd_0;
    assign p_d_w[0][1] = pd_1;

    for (genvar r = 0; r < 2; r++) begin : g_row
        for (genvar c = 0; c < 2; c++) begin : g_col
            systolic_n_body_2x2_cell #(.G(G)) u_cell (
                .clk         (clk),
                .rst_n       (rst_n),
                .in_q_i      (q_i_w[r][c]),
                .in_m_i      (m_i_w[r][c]),
                .in_q_j      (q_j_w[r][c]),
                .in_m_j      (m_j_w[r][c]),
                .in_p_right  (p_r_w[r][c]),
                .in_p_down   (p_d_w[r][c]),
                .out_q_i     (q_i_w[r][c+1]),
                .out_m_i     (m_i_w[r][c+1]),
                .out_q_j     (q_j_w[r+1][c]),
                .out_m_j     (m_j_w[r+1][c]),
                .out_p_right (p_r_w[r][c+1]),
                .out_p_down  (p_d_w[r+1][c])
            );
        end
    end

    assign out_pr_0 = p_r_w[0][2];
    assign out_pr_1 = p_r_w[1][2];
    assign out_pd_0 = p_d_w[2][0];
    assign out_pd_1 = p_d_w[2][1];

endmodule

// File: tb/tb_systolic_2x2.sv
// Directed bench for systolic_2x2: hand-computed gravity sums per scenario.

module tb_systolic_2x2;

    localparam real TOL = 1.0e-12;

    logic clk;
    logic rst_n;
    real  q_0i, q_1i, q_0j, q_1j;
    real  m_0i, m_1i, m_0j, m_1j;
    real  pr_0, pr_1, pd_0, pd_1;
    real  out_pr_0, out_pr_1, out_pd_0, out_pd_1;

    int   n_cmp;
    int   n_err;

    systolic_2x2 #(.G(1.0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .q_0i     (q_0i),
        .q_1i     (q_1i),
        .q_0j     (q_0j),
        .q_1j     (q_1j),
        .m_0i     (m_0i),
        .m_1i     (m_1i),
        .m_0j     (m_0j),
        .m_1j     (m_1j),
        .pr_0     (pr_0),
        .pr_1     (pr_1),
        .pd_0     (pd_0),
        .pd_1     (pd_1),
        .out_pr_0 (out_pr_0),
        .out_pr_1 (out_pr_1),
        .out_pd_0 (out_pd_0),
        .out_pd_1 (out_pd_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bubble();
        q_0i = 0.0; q_1i = 0.0; q_0j = 0.0; q_1j = 0.0;
        m_0i = 0.0; m_1i = 0.0; m_0j = 0.0; m_1j = 0.0;
        pr_0 = 0.0; pr_1 = 0.0; pd_0 = 0.0; pd_1 = 0.0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single i/j pair entering C(0,0) only.
    task automatic drive_pair00(input real qi, input real qj);
        bubble();
        q_0i = qi; q_0j = qj; m_0i = 1.0; m_0j = 1.0;
    endtask

    task automatic test_reset();
        bubble();
        drive_pair00(-2.0, -1.0);
        pr_0 = 0.5; pd_0 = 0.25; pr_1 = 0.75; pd_1 = 0.125;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_pr_0 != 0.0) begin n_err++; $display("FAIL reset_pr_0 got %g want 0.0", out_pr_0); end
        n_cmp++; if (out_pr_1 != 0.0) begin n_err++; $display("FAIL reset_pr_1 got %g want 0.0", out_pr_1); end
        n_cmp++; if (out_pd_0 != 0.0) begin n_err++; $display("FAIL reset_pd_0 got %g want 0.0", out_pd_0); end
        n_cmp++; if (out_pd_1 != 0.0) begin n_err++; $display("FAIL reset_pd_1 got %g want 0.0", out_pd_1); end
        tick();
        bubble();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_single_cell();
        real qj_tab [3];
        real exp_tab [3];
        qj_tab[0] = -1.0; exp_tab[0] = 1.0;
        qj_tab[1] = 1.0;  exp_tab[1] = 1.0 / 9.0;
        qj_tab[2] = 2.0;  exp_tab[2] = 0.0625;
        for (int t = 0; t < 3; t++) begin
            drive_pair00(-2.0, qj_tab[t]);
            tick();
            bubble();
            tick();
            n_cmp++;
            if (!((out_pr_0 - exp_tab[t]) <= TOL && (exp_tab[t] - out_pr_0) <= TOL)) begin
                n_err++; $display("FAIL cell_pr[%0d] got %g want %g", t, out_pr_0, exp_tab[t]);
            end
            n_cmp++;
            if (!((out_pd_0 + exp_tab[t]) <= TOL && (-exp_tab[t] - out_pd_0) <= TOL)) begin
                n_err++; $display("FAIL cell_pd[%0d] got %g want %g", t, out_pd_0, -exp_tab[t]);
            end
        end
    endtask

    task automatic test_single_pair();
        real e;
        e = 1.0 / 9.0;
        drive_pair00(-2.0, 1.0);
        tick();
        bubble();
        tick();
        n_cmp++;
        if (!((out_pr_0 - e) <= TOL && (e - out_pr_0) <= TOL)) begin
            n_err++; $display("FAIL pair_pr_0 got %g want %g", out_pr_0, e);
        end
        n_cmp++;
        if (!((out_pd_0 + e) <= TOL && (-e - out_pd_0) <= TOL)) begin
            n_err++; $display("FAIL pair_pd_0 got %g want %g", out_pd_0, -e);
        end
        tick();
    endtask

    task automatic test_four_body();
        real e_pr0, e_pd0, e_pr1, e_pd1;
        e_pr0 = 25.0 / 144.0;
        e_pd0 = -13.0 / 36.0;
        e_pr1 = 13.0 / 36.0;
        e_pd1 = -25.0 / 144.0;
        drive_pair00(-2.0, 1.0);
        tick();
        bubble();
        q_1i = -1.0; q_1j = 2.0; m_1i = 1.0; m_1j = 1.0;
        tick();
        n_cmp++;
        if (!((out_pr_0 - e_pr0) <= TOL && (e_pr0 - out_pr_0) <= TOL)) begin
            n_err++; $display("FAIL four_pr_0 got %g want %g", out_pr_0, e_pr0);
        end
        n_cmp++;
        if (!((out_pd_0 - e_pd0) <= TOL && (e_pd0 - out_pd_0) <= TOL)) begin
            n_err++; $display("FAIL four_pd_0 got %g want %g", out_pd_0, e_pd0);
        end
        bubble();
        tick();
        n_cmp++;
        if (!((out_pr_1 - e_pr1) <= TOL && (e_pr1 - out_pr_1) <= TOL)) begin
            n_err++; $display("FAIL four_pr_1 got %g want %g", out_pr_1, e_pr1);
        end
        n_cmp++;
        if (!((out_pd_1 - e_pd1) <= TOL && (e_pd1 - out_pd_1) <= TOL)) begin
            n_err++; $display("FAIL four_pd_1 got %g want %g", out_pd_1, e_pd1);
        end
        tick();
    endtask

    task automatic test_diagonal();
        drive_pair00(-2.0, -2.0);
        pr_0 = 0.5; pd_0 = 0.25;
        tick();
        bubble();
        tick();
        n_cmp++;
        if (!((out_pr_0 - 0.5) <= TOL && (0.5 - out_pr_0) <= TOL)) begin
            n_err++; $display("FAIL diag_pr_0 got %g want 0.5", out_pr_0);
        end
        n_cmp++;
        if (!((out_pd_0 - 0.25) <= TOL && (0.25 - out_pd_0) <= TOL)) begin
            n_err++; $display("FAIL diag_pd_0 got %g want 0.25", out_pd_0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        real e;
        e = 1.0 / 9.0;
        drive_pair00(-2.0, 1.0);
        tick();
        drive_pair00(-2.0, -1.0);
        tick();
        n_cmp++;
        if (!((out_pr_0 - e) <= TOL && (e - out_pr_0) <= TOL)) begin
            n_err++; $display("FAIL b2b_a_pr_0 got %g want %g", out_pr_0, e);
        end
        n_cmp++;
        if (!((out_pd_0 + e) <= TOL && (-e - out_pd_0) <= TOL)) begin
            n_err++; $display("FAIL b2b_a_pd_0 got %g want %g", out_pd_0, -e);
        end
        bubble();
        tick();
        n_cmp++;
        if (!((out_pr_0 - 1.0) <= TOL && (1.0 - out_pr_0) <= TOL)) begin
            n_err++; $display("FAIL b2b_b_pr_0 got %g want 1.0", out_pr_0);
        end
        n_cmp++;
        if (!((out_pd_0 + 1.0) <= TOL && (-1.0 - out_pd_0) <= TOL)) begin
            n_err++; $display("FAIL b2b_b_pd_0 got %g want -1.0", out_pd_0);
        end
        tick();
    endtask

    task automatic test_midrun_reset();
        drive_pair00(-2.0, 1.0);
        q_1i = -1.0; q_1j = 2.0; m_1i = 1.0; m_1j = 1.0;
        pr_0 = 0.5; pr_1 = 0.5; pd_0 = 0.5; pd_1 = 0.5;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_pr_0 != 0.0) begin n_err++; $display("FAIL mid_rst_pr_0 got %g want 0.0", out_pr_0); end
        n_cmp++; if (out_pr_1 != 0.0) begin n_err++; $display("FAIL mid_rst_pr_1 got %g want 0.0", out_pr_1); end
        n_cmp++; if (out_pd_0 != 0.0) begin n_err++; $display("FAIL mid_rst_pd_0 got %g want 0.0", out_pd_0); end
        n_cmp++; if (out_pd_1 != 0.0) begin n_err++; $display("FAIL mid_rst_pd_1 got %g want 0.0", out_pd_1); end
        bubble();
        #1 rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (out_pr_0 != 0.0) begin n_err++; $display("FAIL post_rst_pr_0 got %g want 0.0", out_pr_0); end
        n_cmp++; if (out_pr_1 != 0.0) begin n_err++; $display("FAIL post_rst_pr_1 got %g want 0.0", out_pr_1); end
        n_cmp++; if (out_pd_0 != 0.0) begin n_err++; $display("FAIL post_rst_pd_0 got %g want 0.0", out_pd_0); end
        n_cmp++; if (out_pd_1 != 0.0) begin n_err++; $display("FAIL post_rst_pd_1 got %g want 0.0", out_pd_1); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        bubble();
        #2;
        test_reset();
        test_single_cell();
        test_single_pair();
        test_four_body();
        test_diagonal();
        test_back_to_back();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
